// File: rtl/obi_arb_pkg.sv
// obi_arb_pkg: source IDs, defaults and request payload shared by the OBI memory arbiter
package obi_arb_pkg;
  typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} src_e;
  localparam int DEF_MAX_OUTSTANDING = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  typedef struct packed {
    logic                    we;
    logic [DEF_DATA_W/8-1:0] be;
    logic [DEF_ADDR_W-1:0]   addr;
    logic [DEF_DATA_W-1:0]   wdata;
  } obi_req_t;
endpackage

// File: rtl/obi_arb_id_fifo.sv
// obi_arb_id_fifo: in-order 1-bit source-ID FIFO, wrap-bit pointers for full/empty
module obi_arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW > 0 ? AW : 1;
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [(1<<IW)-1:0] mem;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == (rd_ptr ^ (AW+1)'(DEPTH));
  assign dout = mem[IW'(rd_ptr)];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem <= '0;
    end else begin
      if (push && !full) begin
        mem[IW'(wr_ptr)] <= din;
        wr_ptr <= wr_ptr + ONE;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + ONE;
    end
endmodule

// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: round-robin share of one OBI memory port between fetch and data ports
// OBI_ARB_PERF_EN adds saturating per-port stall counters
module obi_mem_arbiter
  import obi_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                instr_req_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [DATA_W-1:0]   instr_rdata_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
`ifdef OBI_ARB_PERF_EN
  ,
  output logic [31:0]         instr_stall_cnt_o,
  output logic [31:0]         data_stall_cnt_o
`endif
);
  src_e last_q, lock_src_q, sel, head;
  logic lock_q, sel_req, full, empty, push, pop, head_bit;
  assign sel = lock_q ? lock_src_q :
               (instr_req_i && data_req_i) ? (last_q == SRC_INSTR ? SRC_DATA : SRC_INSTR) :
               (data_req_i ? SRC_DATA : SRC_INSTR);
  assign sel_req = sel == SRC_DATA ? data_req_i : instr_req_i;
  // a full ID FIFO blocks new requests even when a response drains it this cycle
  assign mem_req_o = rst_ni && sel_req && !full;
  assign push = mem_req_o && mem_gnt_i;
  assign pop = rst_ni && mem_rvalid_i && !empty;
  assign instr_gnt_o = push && sel == SRC_INSTR;
  assign data_gnt_o = push && sel == SRC_DATA;
  assign mem_we_o = rst_ni && sel == SRC_DATA && data_we_i;
  assign mem_be_o = !rst_ni ? '0 : sel == SRC_DATA ? data_be_i : '1;
  assign mem_addr_o = !rst_ni ? '0 : sel == SRC_DATA ? data_addr_i : instr_addr_i;
  assign mem_wdata_o = (rst_ni && sel == SRC_DATA) ? data_wdata_i : '0;
  assign head = src_e'(head_bit);
  assign instr_rvalid_o = pop && head == SRC_INSTR;
  assign data_rvalid_o = pop && head == SRC_DATA;
  assign instr_rdata_o = rst_ni ? mem_rdata_i : '0;
  assign data_rdata_o = rst_ni ? mem_rdata_i : '0;
  obi_arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (push),
    .pop   (pop),
    .din   (sel),
    .dout  (head_bit),
    .full  (full),
    .empty (empty)
  );
  // the lock keeps the mux on an ungranted request, including through full stalls
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      last_q <= SRC_INSTR;
      lock_q <= 1'b0;
      lock_src_q <= SRC_INSTR;
    end else begin
      if (push) last_q <= sel;
      if (mem_req_o) begin
        lock_q <= !mem_gnt_i;
        lock_src_q <= sel;
      end else if (!sel_req) lock_q <= 1'b0;
    end
`ifdef OBI_ARB_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      instr_stall_cnt_o <= '0;
      data_stall_cnt_o <= '0;
    end else begin
      if (instr_req_i && !instr_gnt_o && !(&instr_stall_cnt_o)) instr_stall_cnt_o <= instr_stall_cnt_o + 32'd1;
      if (data_req_i && !data_gnt_o && !(&data_stall_cnt_o)) data_stall_cnt_o <= data_stall_cnt_o + 32'd1;
    end
`endif
`ifndef SYNTHESIS
  orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni) mem_rvalid_i |-> !empty)
    else $warning("obi_mem_arbiter: response with no outstanding request dropped");
`endif
endmodule
